// File: rtl/lsu_if.sv
// Bundle of the lsu pipeline handshake and data-memory bus.
// The lsu drives the memory bus, so it takes the master modport; the environment takes slave.
interface lsu_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned OPT_WIDTH = 4
);
  logic [XLEN-1:0]      i_exu_res;
  logic [XLEN-1:0]      i_rs2;
  logic [OPT_WIDTH-1:0] i_lsu_opt;
  logic [4:0]           i_rd_idx;
  logic                 i_rd_wen;
  logic                 i_pre_valid;
  logic                 o_pre_ready;
  logic                 o_post_valid;
  logic                 i_post_ready;
  logic [XLEN-1:0]      o_lsu_res;
  logic [4:0]           o_rd_idx;
  logic                 o_rd_wen;
  logic                 o_misalign;
  logic                 o_mem_req_valid;
  logic                 i_mem_req_ready;
  logic [XLEN-1:0]      o_mem_addr;
  logic                 o_mem_wen;
  logic [XLEN-1:0]      o_mem_wdata;
  logic [3:0]           o_mem_wmask;
  logic                 i_mem_rsp_valid;
  logic [XLEN-1:0]      i_mem_rdata;
  logic                 o_mem_rsp_ready;

  modport master (
    input  i_exu_res, i_rs2, i_lsu_opt, i_rd_idx, i_rd_wen, i_pre_valid, i_post_ready,
    input  i_mem_req_ready, i_mem_rsp_valid, i_mem_rdata,
    output o_pre_ready, o_post_valid, o_lsu_res, o_rd_idx, o_rd_wen, o_misalign,
    output o_mem_req_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask, o_mem_rsp_ready
  );

  modport slave (
    output i_exu_res, i_rs2, i_lsu_opt, i_rd_idx, i_rd_wen, i_pre_valid, i_post_ready,
    output i_mem_req_ready, i_mem_rsp_valid, i_mem_rdata,
    input  o_pre_ready, o_post_valid, o_lsu_res, o_rd_idx, o_rd_wen, o_misalign,
    input  o_mem_req_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask, o_mem_rsp_ready
  );
endinterface

// File: rtl/lsu.sv
// Load/store stage: one data-memory transaction per instruction, load alignment/extension,
// and rd hand-off to write-back over a valid/ready pipeline handshake.
module lsu #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned OPT_WIDTH = 4
) (
  input  logic   i_clk,
  input  logic   i_rst,
  lsu_if.master  lsu_bus
);

  localparam logic [OPT_WIDTH-1:0] OptLb  = OPT_WIDTH'(1);
  localparam logic [OPT_WIDTH-1:0] OptLh  = OPT_WIDTH'(2);
  localparam logic [OPT_WIDTH-1:0] OptLw  = OPT_WIDTH'(3);
  localparam logic [OPT_WIDTH-1:0] OptLbu = OPT_WIDTH'(4);
  localparam logic [OPT_WIDTH-1:0] OptLhu = OPT_WIDTH'(5);
  localparam logic [OPT_WIDTH-1:0] OptSb  = OPT_WIDTH'(8);
  localparam logic [OPT_WIDTH-1:0] OptSh  = OPT_WIDTH'(9);
  localparam logic [OPT_WIDTH-1:0] OptSw  = OPT_WIDTH'(10);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  // Access size code: 0 = not a memory op, 1 = byte, 2 = half, 3 = word.
  function automatic logic [1:0] op_size(input logic [OPT_WIDTH-1:0] opt);
    logic [1:0] sz;
    sz = 2'd0;
    if (opt == OptLb || opt == OptLbu || opt == OptSb) sz = 2'd1;
    if (opt == OptLh || opt == OptLhu || opt == OptSh) sz = 2'd2;
    if (opt == OptLw || opt == OptSw) sz = 2'd3;
    return sz;
  endfunction

  function automatic logic is_store(input logic [OPT_WIDTH-1:0] opt);
    return (opt == OptSb) || (opt == OptSh) || (opt == OptSw);
  endfunction

  state_e               state_q, state_d;
  logic [XLEN-1:0]      addr_q, rs2_q, res_q, res_d;
  logic [OPT_WIDTH-1:0] opt_q;
  logic [4:0]           rd_idx_q;
  logic                 rd_wen_q, rd_wen_d, misalign_q, misalign_d;
  logic                 capture;

  logic [1:0]      in_size, q_size;
  logic            in_misalign, q_store, req_phase;
  logic [4:0]      lane_shift;
  logic [XLEN-1:0] rd_word, load_data;

  assign in_size     = op_size(lsu_bus.i_lsu_opt);
  assign in_misalign = (in_size == 2'd2 && lsu_bus.i_exu_res[0]) ||
                       (in_size == 2'd3 && lsu_bus.i_exu_res[1:0] != 2'b00);
  assign q_size      = op_size(opt_q);
  assign q_store     = is_store(opt_q);
  assign lane_shift  = {addr_q[1:0], 3'b000};
  assign rd_word     = lsu_bus.i_mem_rdata >> lane_shift;

  always_comb begin
    load_data = rd_word;
    if (opt_q == OptLb)  load_data = {{(XLEN-8){rd_word[7]}}, rd_word[7:0]};
    if (opt_q == OptLbu) load_data = {{(XLEN-8){1'b0}}, rd_word[7:0]};
    if (opt_q == OptLh)  load_data = {{(XLEN-16){rd_word[15]}}, rd_word[15:0]};
    if (opt_q == OptLhu) load_data = {{(XLEN-16){1'b0}}, rd_word[15:0]};
  end

  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    rd_wen_d   = rd_wen_q;
    misalign_d = misalign_q;
    capture    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (lsu_bus.i_pre_valid) begin
          capture    = 1'b1;
          res_d      = lsu_bus.i_exu_res;
          rd_wen_d   = lsu_bus.i_rd_wen;
          misalign_d = 1'b0;
          if (in_size == 2'd0) begin
            state_d = StDone;
          end else if (in_misalign) begin
            res_d      = '0;
            rd_wen_d   = 1'b0;
            misalign_d = 1'b1;
            state_d    = StDone;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: if (lsu_bus.i_mem_req_ready) state_d = StResp;
      // Only responses seen here count; one coincident with the request handshake is dropped.
      StResp: begin
        if (lsu_bus.i_mem_rsp_valid) begin
          state_d = StDone;
          if (q_store) rd_wen_d = 1'b0;
          else         res_d    = load_data;
        end
      end
      StDone: if (lsu_bus.i_post_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rs2_q      <= '0;
      opt_q      <= '0;
      rd_idx_q   <= '0;
      res_q      <= '0;
      rd_wen_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_q      <= res_d;
      rd_wen_q   <= rd_wen_d;
      misalign_q <= misalign_d;
      if (capture) begin
        addr_q   <= lsu_bus.i_exu_res;
        rs2_q    <= lsu_bus.i_rs2;
        opt_q    <= lsu_bus.i_lsu_opt;
        rd_idx_q <= lsu_bus.i_rd_idx;
      end
    end
  end

  assign req_phase = (state_q == StReq);

  always_comb begin
    lsu_bus.o_mem_wmask = 4'h0;
    if (req_phase) begin
      lsu_bus.o_mem_wmask = 4'hF;
      if (q_store && q_size == 2'd1) lsu_bus.o_mem_wmask = 4'b0001 << addr_q[1:0];
      if (q_store && q_size == 2'd2) lsu_bus.o_mem_wmask = 4'b0011 << addr_q[1:0];
    end
  end

  assign lsu_bus.o_pre_ready     = (state_q == StIdle);
  assign lsu_bus.o_post_valid    = (state_q == StDone);
  assign lsu_bus.o_mem_req_valid = req_phase;
  assign lsu_bus.o_mem_rsp_ready = (state_q == StResp);
  assign lsu_bus.o_mem_addr      = req_phase ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign lsu_bus.o_mem_wen       = req_phase & q_store;
  assign lsu_bus.o_mem_wdata     = (req_phase && q_store) ? (rs2_q << lane_shift) : '0;
  assign lsu_bus.o_lsu_res       = res_q;
  assign lsu_bus.o_rd_idx        = rd_idx_q;
  assign lsu_bus.o_rd_wen        = rd_wen_q;
  assign lsu_bus.o_misalign      = misalign_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus random ops against a behavioural model.
module tb_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if #(.XLEN(32), .OPT_WIDTH(4)) bus ();

  lsu #(.XLEN(32), .OPT_WIDTH(4)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .lsu_bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] last_res, last_addr, last_wdata;
  logic [3:0]  last_wmask;
  logic        last_wen, last_mis;

  typedef struct packed {
    logic        mem;
    logic        store;
    logic        misal;
    logic        chk_res;
    logic [31:0] res;
    logic        rd_wen;
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: derived directly from the opcode table and lane rules.
  function automatic exp_t model(input int opt, input logic [31:0] addr, input logic [31:0] rs2,
                                 input logic [31:0] rdata, input logic wen);
    exp_t e;
    int off, sz;
    logic [31:0] v;
    off = int'(addr % 4);
    case (opt)
      1, 4, 8: sz = 1;
      2, 5, 9: sz = 2;
      3, 10:   sz = 4;
      default: sz = 0;
    endcase
    e = '0;
    e.store = (opt >= 8);
    e.addr  = addr & 32'hFFFF_FFFC;
    if (sz == 0) begin
      e.chk_res = 1; e.res = addr; e.rd_wen = wen;
    end else if (off % sz != 0) begin
      e.misal = 1; e.chk_res = 1; e.res = 0; e.rd_wen = 0;
    end else begin
      e.mem = 1;
      if (e.store) begin
        e.wmask = 4'(((1 << sz) - 1) << off);
        e.wdata = rs2 << (8 * off);
        e.rd_wen = 0;
      end else begin
        e.wmask = 4'hF;
        e.rd_wen = wen;
        e.chk_res = 1;
        v = rdata >> (8 * off);
        if (sz == 1) begin
          v = v & 32'hFF;
          if (opt == 1 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
          v = v & 32'hFFFF;
          if (opt == 2 && v[15]) v = v | 32'hFFFF_0000;
        end
        e.res = v;
      end
    end
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input int opt, input logic [31:0] exu, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic wen, input int rqw, input int rsw,
                        input int pw, input logic [31:0] rdata);
    exp_t e;
    e = model(opt, exu, rs2, rdata, wen);
    check("pre_ready_idle", 32'(bus.o_pre_ready), 32'd1);
    bus.i_pre_valid = 1'b1;
    bus.i_exu_res   = exu;
    bus.i_rs2       = rs2;
    bus.i_lsu_opt   = 4'(opt);
    bus.i_rd_idx    = rd;
    bus.i_rd_wen    = wen;
    @(negedge clk);
    bus.i_pre_valid = 1'b0;
    bus.i_exu_res   = $urandom;
    bus.i_rs2       = $urandom;
    bus.i_lsu_opt   = 4'($urandom);
    bus.i_rd_idx    = 5'($urandom);
    bus.i_rd_wen    = 1'($urandom);
    if (e.mem) begin
      for (int i = 0; i <= rqw; i++) begin
        check("req_valid", 32'(bus.o_mem_req_valid), 32'd1);
        check("req_addr", bus.o_mem_addr, e.addr);
        check("req_wen", 32'(bus.o_mem_wen), 32'(e.store));
        check("req_wmask", 32'(bus.o_mem_wmask), 32'(e.wmask));
        if (e.store) check("req_wdata", bus.o_mem_wdata, e.wdata);
        check("pre_ready_busy", 32'(bus.o_pre_ready), 32'd0);
        check("post_valid_req", 32'(bus.o_post_valid), 32'd0);
        if (i == 0) begin
          last_addr = bus.o_mem_addr; last_wmask = bus.o_mem_wmask; last_wdata = bus.o_mem_wdata;
        end
        if (i == rqw) begin
          bus.i_mem_req_ready = 1'b1;
          bus.i_mem_rsp_valid = 1'b1;  // coincident response must be ignored
          bus.i_mem_rdata     = ~rdata;
        end
        @(negedge clk);
      end
      bus.i_mem_req_ready = 1'b0;
      bus.i_mem_rsp_valid = 1'b0;
      for (int i = 0; i <= rsw; i++) begin
        check("rsp_ready", 32'(bus.o_mem_rsp_ready), 32'd1);
        check("req_dropped", 32'(bus.o_mem_req_valid), 32'd0);
        check("post_valid_rsp", 32'(bus.o_post_valid), 32'd0);
        if (i == rsw) begin
          bus.i_mem_rsp_valid = 1'b1;
          bus.i_mem_rdata     = rdata;
        end
        @(negedge clk);
      end
      bus.i_mem_rsp_valid = 1'b0;
      bus.i_mem_rdata     = $urandom;
    end
    for (int i = 0; i <= pw; i++) begin
      check("post_valid", 32'(bus.o_post_valid), 32'd1);
      check("pre_ready_done", 32'(bus.o_pre_ready), 32'd0);
      check("no_req_done", 32'(bus.o_mem_req_valid), 32'd0);
      if (e.chk_res) check("lsu_res", bus.o_lsu_res, e.res);
      check("rd_idx", 32'(bus.o_rd_idx), 32'(rd));
      check("rd_wen", 32'(bus.o_rd_wen), 32'(e.rd_wen));
      check("misalign", 32'(bus.o_misalign), 32'(e.misal));
      last_res = bus.o_lsu_res; last_wen = bus.o_rd_wen; last_mis = bus.o_misalign;
      if (i == pw) bus.i_post_ready = 1'b1;
      @(negedge clk);
    end
    bus.i_post_ready = 1'b0;
    check("post_valid_clear", 32'(bus.o_post_valid), 32'd0);
    check("pre_ready_back", 32'(bus.o_pre_ready), 32'd1);
  endtask

  initial begin
    int opts[13] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 6, 7, 11, 15};
    bus.i_exu_res = '0; bus.i_rs2 = '0; bus.i_lsu_opt = '0; bus.i_rd_idx = '0;
    bus.i_rd_wen = 1'b0; bus.i_pre_valid = 1'b0; bus.i_post_ready = 1'b0;
    bus.i_mem_req_ready = 1'b0; bus.i_mem_rsp_valid = 1'b0; bus.i_mem_rdata = '0;

    #1;
    check("rst_pre_ready", 32'(bus.o_pre_ready), 32'd1);
    check("rst_post_valid", 32'(bus.o_post_valid), 32'd0);
    check("rst_req_valid", 32'(bus.o_mem_req_valid), 32'd0);
    check("rst_rsp_ready", 32'(bus.o_mem_rsp_ready), 32'd0);
    check("rst_lsu_res", bus.o_lsu_res, 32'd0);
    check("rst_rd_wen", 32'(bus.o_rd_wen), 32'd0);
    check("rst_misalign", 32'(bus.o_misalign), 32'd0);
    check("rst_mem_addr", bus.o_mem_addr, 32'd0);
    check("rst_wmask", 32'(bus.o_mem_wmask), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(0, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 0, 0, 0, 32'h0);
    check("nop_res", last_res, 32'h1234_5678);
    check("nop_wen", 32'(last_wen), 32'd1);

    run_op(1, 32'h8000_0003, 32'h0, 5'd7, 1'b1, 0, 0, 0, 32'h80FF_0000);
    check("lb_addr", last_addr, 32'h8000_0000);
    check("lb_res", last_res, 32'hFFFF_FF80);
    run_op(4, 32'h8000_0003, 32'h0, 5'd7, 1'b1, 0, 0, 0, 32'h80FF_0000);
    check("lbu_res", last_res, 32'h0000_0080);

    run_op(9, 32'h8000_0102, 32'hABCD_1234, 5'd3, 1'b1, 0, 0, 0, 32'h0);
    check("sh_wmask", 32'(last_wmask), 32'h0000_000C);
    check("sh_wdata", last_wdata, 32'h1234_0000);
    check("sh_wen", 32'(last_wen), 32'd0);

    run_op(3, 32'h8000_0010, 32'h0, 5'd9, 1'b1, 3, 2, 2, 32'hCAFE_F00D);
    check("bp_res", last_res, 32'hCAFE_F00D);

    run_op(3, 32'h8000_0002, 32'h0, 5'd4, 1'b1, 0, 0, 0, 32'h0);
    check("mis_flag", 32'(last_mis), 32'd1);
    check("mis_wen", 32'(last_wen), 32'd0);

    // Reset while waiting for the response.
    bus.i_pre_valid = 1'b1; bus.i_exu_res = 32'h8000_0020; bus.i_lsu_opt = 4'd3;
    bus.i_rd_idx = 5'd2; bus.i_rd_wen = 1'b1;
    @(negedge clk);
    bus.i_pre_valid = 1'b0; bus.i_mem_req_ready = 1'b1;
    @(negedge clk);
    bus.i_mem_req_ready = 1'b0;
    check("resp_before_rst", 32'(bus.o_mem_rsp_ready), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_rsp", 32'(bus.o_mem_rsp_ready), 32'd0);
    check("rst_async_req", 32'(bus.o_mem_req_valid), 32'd0);
    check("rst_async_pre", 32'(bus.o_pre_ready), 32'd1);
    bus.i_mem_rsp_valid = 1'b1; bus.i_mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("pending_rsp_post", 32'(bus.o_post_valid), 32'd0);
    check("pending_rsp_pre", 32'(bus.o_pre_ready), 32'd1);
    bus.i_mem_rsp_valid = 1'b0;
    run_op(3, 32'h8000_0020, 32'h0, 5'd2, 1'b1, 1, 1, 0, 32'h0BAD_BEEF);
    check("post_rst_lw", last_res, 32'h0BAD_BEEF);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = $urandom;
      run_op(opts[$urandom_range(0, 12)], a, $urandom, 5'($urandom), 1'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
